// File: rtl/dm_ext.sv
// dm_ext: MIPS MEM-stage data memory with lane-steered stores, extended loads,
// one-cycle registered reads and a post-reset clear sweep.
module dm_ext #(
  parameter int ADDR_W = 13,
  parameter bit DISPLAY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
  input  logic              we,
  input  logic [1:0]        st_op,
  input  logic              re,
  input  logic [2:0]        ld_op,
  output logic [31:0]       dout,
  output logic              rvalid,
  output logic              ades,
  output logic              adel,
  output logic              busy
);
  localparam int WORDS = 2 ** (ADDR_W - 2);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-3:0] cnt_q, cnt_d, idx;
  logic [31:0] dout_q, dout_d;
  logic rvalid_q, rvalid_d;
  logic [31:0] mem [WORDS];
  logic [3:0] be;
  logic [31:0] wdata, cur, merged, lword, lsh, ext;
  logic wr_en, rd_en;
  always_comb begin
    busy = state_q == CLEAR;
    idx = addr[ADDR_W-1:2];
    ades = !busy && we && ((st_op == 2'd0 && addr[1:0] != 2'd0) || (st_op == 2'd1 && addr[0]));
    adel = !busy && re && ((ld_op == 3'd0 && addr[1:0] != 2'd0) || ((ld_op == 3'd1 || ld_op == 3'd2) && addr[0]));
    wr_en = !busy && we && st_op != 2'd3 && !ades;
    rd_en = !busy && re && ld_op <= 3'd4 && !adel;
    be = st_op == 2'd0 ? 4'hf : st_op == 2'd1 ? (addr[1] ? 4'hc : 4'h3) : 4'h1 << addr[1:0];
    wdata = st_op == 2'd0 ? din : st_op == 2'd1 ? {2{din[15:0]}} : {4{din[7:0]}};
    cur = mem[idx];
    merged = cur;
    for (int i = 0; i < 4; i++) merged[8*i +: 8] = be[i] ? wdata[8*i +: 8] : cur[8*i +: 8];
    // write-first: a load in the same cycle as a store sees the merged word
    lword = wr_en ? merged : cur;
    lsh = lword >> {addr[1:0], 3'b000};
    ext = ld_op == 3'd1 ? {{16{lsh[15]}}, lsh[15:0]} :
          ld_op == 3'd2 ? {16'h0, lsh[15:0]} :
          ld_op == 3'd3 ? {{24{lsh[7]}}, lsh[7:0]} :
          ld_op == 3'd4 ? {24'h0, lsh[7:0]} : lword;
    cnt_d = busy ? cnt_q + 1'b1 : cnt_q;
    state_d = (busy && cnt_q == '1) ? READY : state_q;
    rvalid_d = rd_en;
    dout_d = rd_en ? ext : dout_q;
    dout = dout_q;
    rvalid = rvalid_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      dout_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dout_q <= dout_d;
      rvalid_q <= rvalid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (busy) mem[cnt_q] <= '0;
    else if (wr_en) mem[idx] <= merged;
    if (DISPLAY && wr_en) $display("*%h <= %h", 32'(addr), merged);
  end
endmodule

// File: tb/tb_dm_ext.sv
// tb_dm_ext: randomized and directed checks of dm_ext against a byte-array memory model.
module tb_dm_ext;
  logic clk = 1'b0, reset, we, re, rvalid, ades, adel, busy;
  logic [1:0] st_op;
  logic [2:0] ld_op;
  logic [12:0] addr;
  logic [31:0] din, dout;
  int checks = 0, errors = 0;
  logic [7:0] mb [8192];
  logic exp_ades, exp_adel, exp_rv, obs_ades, obs_adel, obs_rv;
  logic [31:0] exp_dout = 32'h0, obs_dout;

  always #5 clk = ~clk;

  dm_ext #(.ADDR_W(13), .DISPLAY(1)) dut (
    .clk(clk), .reset(reset), .addr(addr), .din(din), .we(we), .st_op(st_op),
    .re(re), .ld_op(ld_op), .dout(dout), .rvalid(rvalid), .ades(ades),
    .adel(adel), .busy(busy)
  );

  function automatic logic [31:0] ref_ld(input int a, input int lo);
    int n;
    logic [31:0] v;
    n = (lo == 0) ? 4 : (lo <= 2) ? 2 : 1;
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(mb[a + i]) << (8 * i));
    if ((lo == 1 || lo == 3) && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model(input logic w, input logic [1:0] so, input logic r, input logic [2:0] lo,
                       input int a, input logic [31:0] d);
    int n;
    exp_ades = w && ((so == 0 && a % 4 != 0) || (so == 1 && a % 2 != 0));
    exp_adel = r && ((lo == 0 && a % 4 != 0) || ((lo == 1 || lo == 2) && a % 2 != 0));
    if (w && so != 3 && !exp_ades) begin
      n = (so == 0) ? 4 : (so == 1) ? 2 : 1;
      for (int i = 0; i < n; i++) mb[a + i] = d[8*i +: 8];
    end
    exp_rv = r && lo <= 4 && !exp_adel;
    if (exp_rv) exp_dout = ref_ld(a, int'(lo));
  endtask

  task automatic op(input logic w, input logic [1:0] so, input logic r, input logic [2:0] lo,
                    input logic [12:0] a, input logic [31:0] d);
    model(w, so, r, lo, int'(a), d);
    we = w; st_op = so; re = r; ld_op = lo; addr = a; din = d;
    #1;
    obs_ades = ades;
    obs_adel = adel;
    @(posedge clk); #1;
    obs_rv = rvalid;
    obs_dout = dout;
    we = 1'b0;
    re = 1'b0;
  endtask

  task automatic test_reset;
    int n, bad;
    repeat (3) @(posedge clk);
    #1;
    we = 1'b1; st_op = 2'd0; re = 1'b1; ld_op = 3'd0; addr = 13'h102;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", busy); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", rvalid); end
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout got %h want 0", dout); end
    checks++; if (ades !== 1'b0 || adel !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", ades, adel); end
    @(posedge clk); #1;
    reset = 1'b0;
    n = 0; bad = 0;
    while (busy === 1'b1 && n < 3000) begin
      we = 1'($urandom); re = 1'($urandom); st_op = 2'($urandom); ld_op = 3'($urandom);
      addr = 13'($urandom); din = $urandom;
      #1;
      if (ades !== 1'b0 || adel !== 1'b0) bad++;
      @(posedge clk); #1;
      n++;
      if (rvalid !== 1'b0 || dout !== 32'h0) bad++;
    end
    we = 1'b0; re = 1'b0;
    checks++; if (n != 2048) begin errors++; $display("FAIL sweep_len got %0d want 2048", n); end
    checks++; if (bad != 0) begin errors++; $display("FAIL busy_requests got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_sweep_end;
    op(1'b0, 2'd0, 1'b1, 3'd0, 13'h1FFC, 32'h0);
    checks++; if (obs_rv !== 1'b1) begin errors++; $display("FAIL sweep_end_rvalid got %b want 1", obs_rv); end
    checks++; if (obs_dout !== 32'h0) begin errors++; $display("FAIL sweep_end_dout got %h want 0", obs_dout); end
  endtask

  task automatic test_store_lanes;
    op(1'b1, 2'd0, 1'b0, 3'd0, 13'h100, 32'h11223344);
    checks++; if (obs_ades !== 1'b0 || obs_rv !== 1'b0) begin errors++; $display("FAIL sw_flags got ades=%b rv=%b want 0 0", obs_ades, obs_rv); end
    op(1'b1, 2'd2, 1'b0, 3'd0, 13'h102, 32'hFFFF_FFAA);
    op(1'b1, 2'd1, 1'b0, 3'd0, 13'h100, 32'h1234BEEF);
    op(1'b0, 2'd0, 1'b1, 3'd0, 13'h100, 32'h0);
    checks++; if (obs_rv !== 1'b1) begin errors++; $display("FAIL lanes_rvalid got %b want 1", obs_rv); end
    checks++; if (obs_dout !== 32'h11AABEEF) begin errors++; $display("FAIL lanes_word got %h want 11aabeef", obs_dout); end
  endtask

  task automatic test_load_ext;
    logic [12:0] la [5] = '{13'h203, 13'h203, 13'h200, 13'h202, 13'h202};
    logic [2:0] lo [5] = '{3'd3, 3'd4, 3'd1, 3'd1, 3'd2};
    logic [31:0] want [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00007F01, 32'hFFFF80FF, 32'h000080FF};
    op(1'b1, 2'd0, 1'b0, 3'd0, 13'h200, 32'h80FF7F01);
    for (int i = 0; i < 5; i++) begin
      op(1'b0, 2'd0, 1'b1, lo[i], la[i], 32'h0);
      checks++; if (obs_rv !== 1'b1 || obs_dout !== want[i]) begin errors++; $display("FAIL ext_%0d got rv=%b %h want rv=1 %h", i, obs_rv, obs_dout, want[i]); end
    end
  endtask

  task automatic test_misalign;
    op(1'b1, 2'd0, 1'b0, 3'd0, 13'h102, 32'hDEADBEEF);
    checks++; if (obs_ades !== 1'b1 || obs_adel !== 1'b0) begin errors++; $display("FAIL sw_misalign got ades=%b adel=%b want 1 0", obs_ades, obs_adel); end
    op(1'b1, 2'd1, 1'b0, 3'd0, 13'h101, 32'hDEADBEEF);
    checks++; if (obs_ades !== 1'b1) begin errors++; $display("FAIL sh_misalign got %b want 1", obs_ades); end
    op(1'b0, 2'd0, 1'b1, 3'd0, 13'h100, 32'h0);
    checks++; if (obs_dout !== 32'h11AABEEF) begin errors++; $display("FAIL misalign_nowrite got %h want 11aabeef", obs_dout); end
    op(1'b0, 2'd0, 1'b1, 3'd1, 13'h101, 32'h0);
    checks++; if (obs_adel !== 1'b1 || obs_rv !== 1'b0) begin errors++; $display("FAIL lh_misalign got adel=%b rv=%b want 1 0", obs_adel, obs_rv); end
    checks++; if (obs_dout !== 32'h11AABEEF) begin errors++; $display("FAIL dout_hold got %h want 11aabeef", obs_dout); end
    op(1'b0, 2'd0, 1'b1, 3'd0, 13'h102, 32'h0);
    checks++; if (obs_adel !== 1'b1 || obs_rv !== 1'b0) begin errors++; $display("FAIL lw_misalign got adel=%b rv=%b want 1 0", obs_adel, obs_rv); end
    op(1'b1, 2'd3, 1'b0, 3'd0, 13'h100, 32'hFFFF_FFFF);
    checks++; if (obs_ades !== 1'b0) begin errors++; $display("FAIL rsvd_st_flag got %b want 0", obs_ades); end
    op(1'b0, 2'd0, 1'b1, 3'd5, 13'h101, 32'h0);
    checks++; if (obs_adel !== 1'b0 || obs_rv !== 1'b0) begin errors++; $display("FAIL rsvd_ld got adel=%b rv=%b want 0 0", obs_adel, obs_rv); end
    op(1'b0, 2'd0, 1'b1, 3'd0, 13'h100, 32'h0);
    checks++; if (obs_dout !== 32'h11AABEEF) begin errors++; $display("FAIL rsvd_nowrite got %h want 11aabeef", obs_dout); end
  endtask

  task automatic test_write_first;
    op(1'b1, 2'd2, 1'b1, 3'd0, 13'h300, 32'h55);
    checks++; if (obs_rv !== 1'b1 || obs_dout !== 32'h00000055) begin errors++; $display("FAIL write_first got rv=%b %h want rv=1 00000055", obs_rv, obs_dout); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) op(1'b1, 2'd0, 1'b0, 3'd0, 13'(13'h400 + 4 * i), $urandom);
    for (int i = 0; i < 8; i++) begin
      op(1'b0, 2'd0, 1'b1, 3'(i % 5), 13'(13'h400 + 4 * (7 - i)), 32'h0);
      checks++; if (obs_rv !== 1'b1 || obs_dout !== exp_dout) begin errors++; $display("FAIL b2b_%0d got rv=%b %h want rv=1 %h", i, obs_rv, obs_dout, exp_dout); end
    end
  endtask

  task automatic test_random;
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      op(1'($urandom), 2'($urandom), 1'($urandom), 3'($urandom), 13'(13'h400 + $urandom_range(0, 63)), $urandom);
      checks++;
      if (obs_ades !== exp_ades || obs_adel !== exp_adel || obs_rv !== exp_rv || obs_dout !== exp_dout) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand_%0d got %b%b%b %h want %b%b%b %h", i, obs_ades, obs_adel, obs_rv, obs_dout, exp_ades, exp_adel, exp_rv, exp_dout);
      end
    end
  endtask

  task automatic test_mid_reset;
    int n, bad;
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL async_reset_busy got %b want 1", busy); end
    @(posedge clk); #1;
    reset = 1'b0;
    bad = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (busy !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_sweep_busy got %0d low cycles want 0", bad); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n != 2048) begin errors++; $display("FAIL restart_len got %0d want 2048", n); end
    for (int i = 0; i < 8192; i++) mb[i] = 8'h0;
    op(1'b0, 2'd0, 1'b1, 3'd0, 13'h100, 32'h0);
    checks++; if (obs_rv !== 1'b1 || obs_dout !== 32'h0) begin errors++; $display("FAIL cleared_100 got rv=%b %h want rv=1 0", obs_rv, obs_dout); end
    op(1'b0, 2'd0, 1'b1, 3'd0, 13'h404, 32'h0);
    checks++; if (obs_dout !== exp_dout) begin errors++; $display("FAIL cleared_404 got %h want %h", obs_dout, exp_dout); end
    op(1'b0, 2'd0, 1'b1, 3'd0, 13'h200, 32'h0);
    checks++; if (obs_dout !== 32'h0) begin errors++; $display("FAIL cleared_200 got %h want 0", obs_dout); end
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; re = 1'b0; st_op = 2'd0; ld_op = 3'd0; addr = 13'h0; din = 32'h0;
    for (int i = 0; i < 8192; i++) mb[i] = 8'h0;
    test_reset;
    test_sweep_end;
    test_store_lanes;
    test_load_ext;
    test_misalign;
    test_write_first;
    test_back_to_back;
    test_random;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
